// File: rtl/sdram_arb2.sv
// ============================================================================
// sdram_arb2
// ----------------------------------------------------------------------------
// Two-master WISHBONE arbiter in front of the single SDRAM controller port.
// Master 0 is the CPU path (address already translated by the EMS mapper),
// master 1 is the display/DMA path. The grant is registered and held for the
// owner's whole bus cycle (cyc high); the owner's signals are muxed onto the
// slave port combinationally. A watchdog terminates a transfer whose strobe
// has waited `timeout` cycles without an ack, so a dead slave cannot hang the
// bus.
//
// Build option:
//   SDRAM_ARB_M1_PRIO_EN  defined   -> master 1 always wins simultaneous
//                                      requests from IDLE (display refill).
//                         undefined -> round-robin using the `last` register.
//
// Parameters:
//   timeout   cycles an owner's stb may wait for s_ack_i (1..255)
//
// Ports:
//   wb_clk, wb_rst            clock, asynchronous active-high reset
//   m0_* / m1_*               master-side WISHBONE (adr/dat/sel/cyc/stb/we in,
//                             dat/ack out)
//   s_*_o                     slave-side WISHBONE request to the SDRAM ctrl
//   s_dat_i, s_ack_i          slave read data and acknowledge
//   tmo_o                     one-cycle pulse when the watchdog fires
// ============================================================================
module sdram_arb2 #(
    parameter int unsigned timeout = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,

    // master 0 (CPU)
    input  logic [31:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,

    // master 1 (display / DMA)
    input  logic [31:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,

    // SDRAM slave
    output logic [31:0] s_adr_o,
    output logic [15:0] s_dat_o,
    output logic [1:0]  s_sel_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,

    // watchdog
    output logic        tmo_o
);

    // Watchdog compare value; the counter is 8 bits wide, so timeout must
    // stay within 1..255.
    localparam logic [7:0] TimeoutCnt = 8'(timeout);

    // Data returned to the owner when the watchdog terminates its transfer.
    localparam logic [15:0] TmoData = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;   // most recent owner (0 or 1)
    logic [7:0]  cnt_q, cnt_d;     // watchdog wait counter

    logic        own0;
    logic        own1;
    logic        owned;
    logic        own_stb;          // strobe of the current owner
    logic        at_limit;
    logic        force_tmo;        // watchdog terminates this cycle
    logic        win1;             // master 1 wins a simultaneous request

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Ownership decode and watchdog condition
    // ------------------------------------------------------------------------
    always_comb begin
        own0    = (state_q == StOwn0);
        own1    = (state_q == StOwn1);
        owned   = own0 | own1;
        own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

        at_limit = owned && own_stb && (cnt_q == TimeoutCnt);
        // A real ack in the forcing cycle wins: normal data, no pulse.
        force_tmo = at_limit && !s_ack_i;
    end

    // Tie-break for simultaneous requests from IDLE.
`ifdef SDRAM_ARB_M1_PRIO_EN
    assign win1 = 1'b1;
`else
    assign win1 = ~last_q;
`endif

    // ------------------------------------------------------------------------
    // Next-state: grant only from IDLE, release on the owner's cyc low
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;

        case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (win1) begin
                        state_d = StOwn1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = StOwn0;
                        last_d  = 1'b0;
                    end
                end else if (m0_cyc_i) begin
                    state_d = StOwn0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = StOwn1;
                    last_d  = 1'b1;
                end
            end

            StOwn0: begin
                if (!m0_cyc_i) begin
                    state_d = StIdle;
                end
            end

            StOwn1: begin
                if (!m1_cyc_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Watchdog counter: counts only while the owner strobes without an ack
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (!owned || !own_stb || s_ack_i || force_tmo) begin
            cnt_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Slave-side mux and master-side returns
    // ------------------------------------------------------------------------
    always_comb begin
        s_adr_o  = 32'd0;
        s_dat_o  = 16'd0;
        s_sel_o  = 2'd0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        tmo_o    = force_tmo;

        // Read data is broadcast; ack alone qualifies it. Reset blanks it so
        // every output reads zero while wb_rst is held.
        m0_dat_o = wb_rst ? 16'd0 : s_dat_i;
        m1_dat_o = wb_rst ? 16'd0 : s_dat_i;

        if (own0) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~force_tmo;
            s_we_o   = m0_we_i;
            m0_ack_o = s_ack_i | force_tmo;
            if (force_tmo) begin
                m0_dat_o = TmoData;
            end
        end else if (own1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~force_tmo;
            s_we_o   = m1_we_i;
            m1_ack_o = s_ack_i | force_tmo;
            if (force_tmo) begin
                m1_dat_o = TmoData;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arb2.sv
module tb_sdram_arb2;

    logic        wb_clk;
    logic        wb_rst;
    logic [31:0] m0_adr_i, m1_adr_i;
    logic [15:0] m0_dat_i, m1_dat_i;
    logic [1:0]  m0_sel_i, m1_sel_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [15:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] s_adr_o;
    logic [15:0] s_dat_o;
    logic [1:0]  s_sel_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [15:0] s_dat_i;
    logic        s_ack_i;
    logic        tmo_o;

    int checks = 0;
    int errors = 0;

`ifdef SDRAM_ARB_M1_PRIO_EN
    localparam bit P1 = 1'b1;
`else
    localparam bit P1 = 1'b0;
`endif

    localparam logic [31:0] AdrA = 32'h0000_1000;
    localparam logic [31:0] AdrB = 32'h00B0_0020;

    sdram_arb2 #(.timeout(4)) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_sel_i (m0_sel_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_sel_i (m1_sel_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .tmo_o    (tmo_o)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 16'h7777;
        tick();
        tick();
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++;
            $display("FAIL rst_s_cyc got %b exp 0", s_cyc_o); end
        checks++; if (s_stb_o !== 1'b0) begin errors++;
            $display("FAIL rst_s_stb got %b exp 0", s_stb_o); end
        checks++; if (m0_ack_o !== 1'b0) begin errors++;
            $display("FAIL rst_m0_ack got %b exp 0", m0_ack_o); end
        checks++; if (m0_dat_o !== 16'h0000) begin errors++;
            $display("FAIL rst_m0_dat got %h exp 0000", m0_dat_o); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0; s_dat_i = 16'h0000;
        tick();
        wb_rst = 1'b0;
    endtask

    task automatic test_read();
        m0_adr_i = AdrA; m0_sel_i = 2'b11; m0_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++;
            $display("FAIL read_pregrant_cyc got %b exp 0", s_cyc_o); end
        tick();
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== AdrA) begin errors++;
            $display("FAIL read_grant got cyc=%b adr=%h exp cyc=1 adr=%h", s_cyc_o, s_adr_o,
                     AdrA); end
        tick();
        tick();
        tick();
        s_ack_i = 1'b1; s_dat_i = 16'h1234;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 16'h1234) begin errors++;
            $display("FAIL read_ack got ack=%b dat=%h exp ack=1 dat=1234", m0_ack_o,
                     m0_dat_o); end
        checks++; if (m1_ack_o !== 1'b0 || tmo_o !== 1'b0) begin errors++;
            $display("FAIL read_other got m1_ack=%b tmo=%b exp 0 0", m1_ack_o, tmo_o); end
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        checks++; if (m0_ack_o !== 1'b0) begin errors++;
            $display("FAIL read_ack_once got %b exp 0", m0_ack_o); end
        tick();
        checks++; if (s_cyc_o !== 1'b0 || s_adr_o !== 32'd0) begin errors++;
            $display("FAIL read_idle got cyc=%b adr=%h exp 0 0", s_cyc_o, s_adr_o); end
    endtask

    task automatic test_contention();
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        m0_adr_i = AdrA; m1_adr_i = AdrB;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        checks++; if (s_adr_o !== (P1 ? AdrB : AdrA) || s_cyc_o !== 1'b1) begin errors++;
            $display("FAIL cont_first got adr=%h cyc=%b exp adr=%h cyc=1", s_adr_o, s_cyc_o,
                     P1 ? AdrB : AdrA); end
        s_ack_i = 1'b1; s_dat_i = 16'h00A5;
        #1;
        checks++; if (m0_ack_o !== !P1 || m1_ack_o !== P1) begin errors++;
            $display("FAIL cont_first_ack got m0=%b m1=%b exp m0=%b m1=%b", m0_ack_o, m1_ack_o,
                     !P1, P1); end
        tick();
        s_ack_i = 1'b0;
        if (P1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
        else begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
        tick();
        checks++; if (s_cyc_o !== 1'b0) begin errors++;
            $display("FAIL cont_gap got cyc=%b exp 0", s_cyc_o); end
        tick();
        checks++; if (s_adr_o !== (P1 ? AdrA : AdrB) || s_cyc_o !== 1'b1) begin errors++;
            $display("FAIL cont_second got adr=%h cyc=%b exp adr=%h cyc=1", s_adr_o, s_cyc_o,
                     P1 ? AdrA : AdrB); end
        s_ack_i = 1'b1;
        #1;
        checks++; if (m0_ack_o !== P1 || m1_ack_o !== !P1) begin errors++;
            $display("FAIL cont_second_ack got m0=%b m1=%b exp m0=%b m1=%b", m0_ack_o,
                     m1_ack_o, P1, !P1); end
        tick();
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        m0_adr_i = AdrA; m0_we_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = AdrB;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_adr_i = AdrA + 32'(2 * i);
            m0_dat_i = 16'hC000 + 16'(i);
            m0_stb_i = 1'b1;
            s_ack_i  = 1'b1;
            #1;
            checks++;
            if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_we_o !== 1'b1 ||
                s_adr_o !== AdrA + 32'(2 * i) || s_dat_o !== 16'hC000 + 16'(i)) begin
                errors++;
                $display("FAIL b2b_wr%0d got ack0=%b ack1=%b we=%b adr=%h dat=%h", i,
                         m0_ack_o, m1_ack_o, s_we_o, s_adr_o, s_dat_o);
            end
            tick();
            s_ack_i = 1'b0; m0_stb_i = 1'b0;
            #1;
            checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== AdrA + 32'(2 * i)) begin errors++;
                $display("FAIL b2b_gap%0d got cyc=%b adr=%h exp cyc=1 m0 adr", i, s_cyc_o,
                         s_adr_o); end
            tick();
        end
        m0_cyc_i = 1'b0;
        tick();
        checks++; if (s_cyc_o !== 1'b0) begin errors++;
            $display("FAIL b2b_idle got cyc=%b exp 0", s_cyc_o); end
        tick();
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== AdrB) begin errors++;
            $display("FAIL b2b_m1_grant got cyc=%b adr=%h exp 1 %h", s_cyc_o, s_adr_o, AdrB); end
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m0_we_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        s_dat_i = 16'h5555;
        m0_adr_i = AdrA; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (m0_ack_o !== 1'b0 || tmo_o !== 1'b0) begin errors++;
                $display("FAIL tmo_wait%0d got ack=%b tmo=%b exp 0 0", k, m0_ack_o, tmo_o); end
        end
        tick();
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 16'hFFFF || tmo_o !== 1'b1 ||
            s_stb_o !== 1'b0 || s_cyc_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_force got ack=%b dat=%h tmo=%b stb=%b cyc=%b ack1=%b", m0_ack_o,
                     m0_dat_o, tmo_o, s_stb_o, s_cyc_o, m1_ack_o);
        end
        tick();
        checks++; if (m0_ack_o !== 1'b0 || tmo_o !== 1'b0 || s_stb_o !== 1'b1) begin errors++;
            $display("FAIL tmo_after got ack=%b tmo=%b stb=%b exp 0 0 1", m0_ack_o, tmo_o,
                     s_stb_o); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ack_at_timeout();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        s_ack_i = 1'b1; s_dat_i = 16'hABCD;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 16'hABCD || tmo_o !== 1'b0 ||
            s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL ack_vs_tmo got ack=%b dat=%h tmo=%b stb=%b exp 1 abcd 0 1",
                     m0_ack_o, m0_dat_o, tmo_o, s_stb_o);
        end
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        m1_adr_i = AdrB; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        checks++; if (s_adr_o !== AdrB || s_cyc_o !== 1'b1) begin errors++;
            $display("FAIL rmid_own1 got adr=%h cyc=%b exp %h 1", s_adr_o, s_cyc_o, AdrB); end
        m0_adr_i = AdrA; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        s_ack_i = 1'b1; s_dat_i = 16'h4321;
        #1;
        wb_rst = 1'b1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_adr_o !== 32'd0 ||
            m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_dat_o !== 16'd0 || tmo_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_outs got cyc=%b stb=%b adr=%h ack1=%b ack0=%b dat1=%h tmo=%b",
                     s_cyc_o, s_stb_o, s_adr_o, m1_ack_o, m0_ack_o, m1_dat_o, tmo_o);
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        tick();
        wb_rst = 1'b0;
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++;
            $display("FAIL rmid_idle got cyc=%b exp 0", s_cyc_o); end
        tick();
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== AdrA) begin errors++;
            $display("FAIL rmid_m0_grant got cyc=%b adr=%h exp 1 %h", s_cyc_o, s_adr_o, AdrA); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        wb_rst = 1'b1;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0;

        test_reset();
        test_read();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
